// File: rtl/ctrl_pkg.sv
// Shared types and helpers for the parameterised control path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ctrl_pkg;

    // Round index width covers the largest legal channel count (8).
    localparam int RND_W = 3;
    // Drain counter width covers the largest legal drain length (255).
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ_NEXT = 3'd1,
        ST_MOVE_PTRS = 3'd2,
        ST_READ_PREV = 3'd3,
        ST_DRAIN_END = 3'd4
    } ctrl_state_t;

    // One-hot decode of a round index over the widest legal channel set.
    function automatic logic [7:0] onehot(input logic [RND_W-1:0] idx);
        onehot = 8'd1 << idx;
    endfunction

endpackage

// File: rtl/drain_timer.sv
// Drain countdown: arms once per run, counts count_len-1 down to 0, flags expire.
// Latency: draining rises the clock after arm; expire follows count_len-1 clocks later.
// Backpressure: none; arm is ignored while already draining, clear wins over arm.
module drain_timer
    import ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             clear,
    input  logic [CNT_W-1:0] count_len,
    output logic             draining,
    output logic             expire
);

    logic             draining_q, draining_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Arm once, then count down to zero and hold there until cleared.
    always_comb begin
        draining_d = draining_q;
        cnt_d      = cnt_q;
        if (clear) begin
            draining_d = 1'b0;
            cnt_d      = '0;
        end else if (arm && !draining_q) begin
            draining_d = 1'b1;
            cnt_d      = count_len - CNT_W'(1);
        end else if (draining_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Drain state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            draining_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            draining_q <= draining_d;
            cnt_q      <= cnt_d;
        end
    end

    assign draining = draining_q;
    assign expire   = draining_q && (cnt_q == '0);

endmodule

// File: rtl/param_control_path.sv
// Linked-list datapath sequencer: cycles READ_NEXT/MOVE_PTRS/READ_PREV over N_CH channels, drains, completes.
// Latency: outputs decode combinationally from registered state; completion DRAIN_LEN+1 clocks after first accepted dp_done.
// Backpressure: none; start is taken in IDLE only. Optional CTRL_CYCLE_COUNT_EN adds run_cycles.
module param_control_path
    import ctrl_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int DRAIN_LEN = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            dp_done,
    output logic            dp_reset,
    output logic            load_next,
    output logic            load_prev,
    output logic            load_sum,
    output logic            load_acc,
    output logic            load_len,
    output logic            load_mult,
    output logic [N_CH-1:0] load_mem,
    output logic [N_CH-1:0] mux_adder,
    output logic            mux_mem_add,
    output logic            mux_np_adders,
    output logic            mux_comparator,
    output logic            done,
    output logic            busy
`ifdef CTRL_CYCLE_COUNT_EN
    ,
    output logic [31:0]     run_cycles
`endif
);

    ctrl_state_t      state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [RND_W-1:0] rnd_nxt;
    logic [N_CH-1:0]  oh_cur, oh_nxt;
    logic             arm, clear, draining, expire;

    assign rnd_nxt = (rnd_q == RND_W'(N_CH - 1)) ? '0 : rnd_q + RND_W'(1);
    assign oh_cur  = N_CH'(onehot(rnd_q));
    assign oh_nxt  = N_CH'(onehot(rnd_nxt));

    // Only the first dp_done seen in MOVE_PTRS/READ_PREV arms the drain.
    assign arm   = dp_done && ((state_q == ST_MOVE_PTRS) || (state_q == ST_READ_PREV));
    assign clear = (state_q == ST_DRAIN_END);

    drain_timer u_drain_timer (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .clear     (clear),
        .count_len (CNT_W'(DRAIN_LEN)),
        .draining  (draining),
        .expire    (expire)
    );

    // Next state and round index; an expired drain overrides the normal cycling.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ_NEXT;
                    rnd_d   = '0;
                end
            end
            ST_READ_NEXT: state_d = expire ? ST_DRAIN_END : ST_MOVE_PTRS;
            ST_MOVE_PTRS: state_d = expire ? ST_DRAIN_END : ST_READ_PREV;
            ST_READ_PREV: begin
                if (expire) begin
                    state_d = ST_DRAIN_END;
                end else begin
                    state_d = ST_READ_NEXT;
                    rnd_d   = rnd_nxt;
                end
            end
            ST_DRAIN_END: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM state and round counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    // Output decode; DRAIN_END holds every load low, load_mult included.
    always_comb begin
        dp_reset       = 1'b0;
        load_next      = 1'b0;
        load_prev      = 1'b0;
        load_sum       = 1'b0;
        load_acc       = 1'b0;
        load_len       = 1'b0;
        load_mult      = 1'b0;
        load_mem       = '0;
        mux_adder      = '0;
        mux_mem_add    = 1'b0;
        mux_np_adders  = 1'b0;
        mux_comparator = 1'b0;
        done           = 1'b0;
        busy           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                done     = 1'b1;
                dp_reset = start;
            end
            ST_READ_NEXT: begin
                busy        = 1'b1;
                load_mult   = 1'b1;
                mux_mem_add = 1'b1;
                load_sum    = 1'b1;
                load_len    = !draining;
                load_mem    = oh_cur;
            end
            ST_MOVE_PTRS: begin
                busy           = 1'b1;
                load_mult      = 1'b1;
                mux_comparator = 1'b1;
                load_acc       = 1'b1;
                load_next      = 1'b1;
                load_prev      = 1'b1;
                mux_adder      = oh_cur;
            end
            ST_READ_PREV: begin
                busy          = 1'b1;
                load_mult     = 1'b1;
                mux_mem_add   = 1'b1;
                mux_np_adders = 1'b1;
                load_acc      = 1'b1;
                load_sum      = 1'b1;
                load_len      = !draining;
                load_mem      = oh_nxt;
                mux_adder     = oh_nxt;
            end
            ST_DRAIN_END: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                done = 1'b1;
            end
        endcase
    end

`ifdef CTRL_CYCLE_COUNT_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    // Busy-cycle counter: cleared on start acceptance, saturating, held once idle.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if ((state_q == ST_IDLE) && start) begin
            run_cycles_d = '0;
        end else if (busy && (run_cycles_q != '1)) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles = run_cycles_q;
`endif

endmodule
